dct_stream_ctrl: RTL and testbench
==================================

# dct_stream_ctrl

Streaming controller that sequences the combinational 4-point DCT. It accepts signed 8-bit samples one per handshake, assembles 4-sample blocks, and presents each block to the DCT's `dt_i`. It then registers the DCT's direct (`dt_dir_o`) and inverse (`dt_inv_o`) results and streams them out one coefficient per handshake. Input assembly of block N+1 overlaps with draining of block N.

## Interface
- `CNT_W`, default 16: width of the completed-block counter.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous abort; discards the partial input block and the undrained output block.
- `in_valid_i`  in  1  an input sample is offered.
- `in_ready_o`  out  1  the controller can accept a sample.
- `in_data_i`  in  8 signed  the input sample.
- `dct_dt_o`  out  4x8 signed  block driven to the DCT `dt_i`; element 0 is the first sample received.
- `dct_dir_i`  in  4x10 signed  from the DCT `dt_dir_o`.
- `dct_inv_i`  in  4x8 signed  from the DCT `dt_inv_o`.
- `out_valid_o`  out  1  an output coefficient is valid.
- `out_ready_i`  in  1  the downstream accepts the coefficient.
- `out_dir_o`  out  10 signed  direct coefficient at `out_idx_o`.
- `out_inv_o`  out  8 signed  inverse value at `out_idx_o`.
- `out_idx_o`  out  2  coefficient index, 0..3.
- `out_last_o`  out  1  high when `out_idx_o` is 3 and `out_valid_o` is high.
- `blk_cnt_o`  out  CNT_W  number of blocks fully drained; wraps modulo 2^CNT_W.

## Operation
- **Input side.** Holds a 4-entry buffer `ibuf`, a 2-bit write pointer `wp` and an `in_full` flag.
  - `in_ready_o` = !`in_full`.
  - On accept (`in_valid_i` && `in_ready_o`): `ibuf[wp]` <= `in_data_i` and `wp` increments.
  - On the accept with `wp`==3: `wp` wraps to 0 and `in_full` is set.
- **DCT drive.** `dct_dt_o` = `ibuf` continuously, straight from registers with no combinational path from the inputs.
- **Output side.** Two states.
  - OUT_IDLE: `out_valid_o`=0.
  - OUT_BUSY: `out_valid_o`=1. `out_dir_o`/`out_inv_o` are taken from registered `obuf_dir[rp]`/`obuf_inv[rp]`, and `out_idx_o` = `rp`.
- **Capture.** Occurs on an edge where `in_full` && state==OUT_IDLE && !`flush_i`. On that edge:
  - `obuf_dir` <= `dct_dir_i` and `obuf_inv` <= `dct_inv_i` (all four lanes).
  - `rp` <= 0, state <= OUT_BUSY, `in_full` <= 0.
- **Drain.**
  - Each edge with `out_valid_o` && `out_ready_i` advances `rp`.
  - The handshake at `rp`==3 sends the state to OUT_IDLE and increments `blk_cnt_o`.
- **Stalls.** Low `out_ready_i` holds all output signals stable. Valid must not drop while it is not accepted.
- **Arithmetic.** No arithmetic is done on samples; values pass through bit-exact with sign preserved. `blk_cnt_o` rolls from all-ones to 0.
- **Simultaneous events.**
  - Final drain handshake and `in_full` in the same cycle: state goes to OUT_IDLE on that edge and capture happens on the next edge. There is no same-edge bypass.
  - Input accept while OUT_BUSY: allowed. Filling of the next block is independent of draining.
  - 4th input accept and capture condition: cannot coincide, because `in_full` is 0 while accepting.
- **Flush.** `flush_i`=1 on an edge:
  - `wp`<=0, `in_full`<=0, state<=OUT_IDLE, `rp`<=0.
  - `blk_cnt_o` is unchanged; flush has priority over every other update.
  - `in_ready_o` is still driven as !`in_full`, but any sample accepted in a flush cycle is discarded.
- **Reset.** Asynchronous reset takes effect immediately, including mid-block or mid-drain. Values under reset:
  - `in_ready_o`=1, `out_valid_o`=0, `out_idx_o`=0, `out_last_o`=0.
  - `out_dir_o`=0, `out_inv_o`=0, `dct_dt_o`=all 0, `blk_cnt_o`=0.
  - `ibuf`/`obuf` cleared, state=OUT_IDLE.

## Timing
- Throughput: 1 sample per cycle in and 1 coefficient per cycle out. A sustained rate of 4 samples per 5 cycles worst case, because of the 1-cycle capture gap.
- Latency, with the 4th sample accepted on edge T and the output side idle:
  - `in_full`=1 after T; capture on T+1.
  - `out_valid_o`=1, idx 0, after T+1.
  - Index 3 at the earliest after T+4; `blk_cnt_o` increments on the T+5 edge with `out_ready_i` held high.
- `in_ready_o` is low for at least 1 cycle per block: from after T through capture.
- The DCT path from `dct_dt_o` through the DCT to `dct_dir_i` must settle within one clock period.

## Test plan
- **Basic block.** Reset, then feed 5,10,20,0 back-to-back with `out_ready_i`=1.
  - `dct_dt_o`={5,10,20,0} after the 4th accept.
  - `out_valid_o` rises 2 cycles after the 4th accept.
  - Indices 0..3 come out on consecutive cycles, matching the DCT outputs for that block; `out_last_o` is high on index 3.
  - `blk_cnt_o`=1.
- **Overlap.** Feed 0x27,0x53,0x50,0x06 immediately after the first block while holding `out_ready_i`=0.
  - Second block buffers with `in_ready_o`=0 after its 4th accept.
  - Outputs stay frozen at idx 0 of block 1.
  - Release `out_ready_i`: block 1 drains, block 2 is captured on the cycle after block 1's last handshake.
- **Backpressure.** Toggle `out_ready_i` every cycle.
  - Each coefficient is held stable until its handshake.
  - No index is skipped or repeated.
- **Flush mid-block.** Accept 2 samples, pulse `flush_i`, then feed -128,127,-1,0.
  - `dct_dt_o`={-128,127,-1,0}, confirming the pointer restarted at 0.
  - `blk_cnt_o` is unchanged by the flush.
- **Async reset mid-drain.** Assert `rst_i` between clock edges during idx 2.
  - `out_valid_o` goes to 0 immediately.
  - `blk_cnt_o`=0, `in_ready_o`=1.
- **Counter wrap.** With `CNT_W`=2, drain 5 blocks: `blk_cnt_o` sequence is 1,2,3,0,1.

Source files
------------

// File: rtl/dct_stream_ctrl_if.sv
// Handshake and data bundle between the DCT stream controller and its
// environment (sample source, combinational DCT and coefficient sink).
interface dct_stream_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic signed [7:0] in_data_i;

  logic signed [7:0] dct_dt_o  [4];
  logic signed [9:0] dct_dir_i [4];
  logic signed [7:0] dct_inv_i [4];

  logic              out_valid_o;
  logic              out_ready_i;
  logic signed [9:0] out_dir_o;
  logic signed [7:0] out_inv_o;
  logic [1:0]        out_idx_o;
  logic              out_last_o;
  logic [CNT_W-1:0]  blk_cnt_o;

  // Environment side: supplies samples, DCT results and sink readiness.
  modport master (
    output flush_i, in_valid_i, in_data_i, dct_dir_i, dct_inv_i, out_ready_i,
    input  in_ready_o, dct_dt_o, out_valid_o, out_dir_o, out_inv_o,
           out_idx_o, out_last_o, blk_cnt_o
  );

  // Controller side.
  modport slave (
    input  flush_i, in_valid_i, in_data_i, dct_dir_i, dct_inv_i, out_ready_i,
    output in_ready_o, dct_dt_o, out_valid_o, out_dir_o, out_inv_o,
           out_idx_o, out_last_o, blk_cnt_o
  );
endinterface

// File: rtl/dct_stream_ctrl.sv
// Streaming sequencer around a combinational 4-point DCT.
// Samples are gathered into a 4-entry input buffer that drives the DCT
// directly; once full, the DCT results are snapshotted into an output
// buffer and streamed out one coefficient per handshake while the next
// input block is already being gathered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OUT_IDLE | no coefficients held; waiting for a full input block
// OUT_BUSY | streaming obuf[rp]; returns to idle after the idx-3 handshake
module dct_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  dct_stream_ctrl_if.slave bus
);

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_t;

  out_state_t state_q;
  out_state_t state_d;

  logic signed [7:0] ibuf [4];
  logic [1:0]        wp;
  logic              in_full;

  logic signed [9:0] obuf_dir [4];
  logic signed [7:0] obuf_inv [4];
  logic [1:0]        rp;
  logic [CNT_W-1:0]  blk_cnt;

  logic accept;
  logic capture;
  logic drain;
  logic drain_last;

  // Event decode; flush masks every update so a flush cycle is a pure restart.
  always_comb begin
    accept     = 1'b0;
    capture    = 1'b0;
    drain      = 1'b0;
    drain_last = 1'b0;
    if (!bus.flush_i) begin
      accept     = bus.in_valid_i && !in_full;
      capture    = in_full && (state_q == OUT_IDLE);
      drain      = (state_q == OUT_BUSY) && bus.out_ready_i;
      drain_last = drain && (rp == 2'd3);
    end
  end

  // Output-side next state; capture only from idle, so a final drain and
  // a pending full block resolve over two edges rather than a bypass.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = OUT_IDLE;
    end else begin
      case (state_q)
        OUT_IDLE: if (capture)    state_d = OUT_BUSY;
        OUT_BUSY: if (drain_last) state_d = OUT_IDLE;
        default:                  state_d = OUT_IDLE;
      endcase
    end
  end

  // Output-side state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= OUT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Input assembly: write pointer, sample buffer and block-full flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        ibuf[i] <= '0;
      end
      wp      <= '0;
      in_full <= 1'b0;
    end else if (bus.flush_i) begin
      wp      <= '0;
      in_full <= 1'b0;
    end else begin
      if (accept) begin
        ibuf[wp] <= bus.in_data_i;
        wp       <= wp + 2'd1;
        if (wp == 2'd3) begin
          in_full <= 1'b1;
        end
      end
      // accept and capture are exclusive: accept needs !in_full.
      if (capture) begin
        in_full <= 1'b0;
      end
    end
  end

  // Output buffer snapshot, read pointer and completed-block counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        obuf_dir[i] <= '0;
        obuf_inv[i] <= '0;
      end
      rp      <= '0;
      blk_cnt <= '0;
    end else if (bus.flush_i) begin
      rp <= '0;
    end else if (capture) begin
      for (int i = 0; i < 4; i++) begin
        obuf_dir[i] <= bus.dct_dir_i[i];
        obuf_inv[i] <= bus.dct_inv_i[i];
      end
      rp <= '0;
    end else if (drain) begin
      rp <= rp + 2'd1;
      if (drain_last) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready_o = !in_full;
  assign bus.dct_dt_o   = ibuf;

  assign bus.out_valid_o = (state_q == OUT_BUSY);
  assign bus.out_dir_o   = obuf_dir[rp];
  assign bus.out_inv_o   = obuf_inv[rp];
  assign bus.out_idx_o   = rp;
  assign bus.out_last_o  = (state_q == OUT_BUSY) && (rp == 2'd3);
  assign bus.blk_cnt_o   = blk_cnt;

endmodule

// File: tb/tb_dct_stream_ctrl.sv
// Directed bench for dct_stream_ctrl. A stand-in DCT is modelled with
// simple butterflies (dir) and lane reversal (inv) so every lane is
// distinguishable; a second instance with a 2-bit counter shares the
// stimulus for the wrap check.
module tb_dct_stream_ctrl;

  logic clk;
  logic rst;
  logic flush;
  logic in_valid;
  logic signed [7:0] in_data;
  logic out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  dct_stream_ctrl_if #(.CNT_W(16)) m_if ();
  dct_stream_ctrl_if #(.CNT_W(2))  w_if ();

  dct_stream_ctrl #(.CNT_W(16)) u_dut (.clk_i(clk), .rst_i(rst), .bus(m_if.slave));
  dct_stream_ctrl #(.CNT_W(2))  u_wrap (.clk_i(clk), .rst_i(rst), .bus(w_if.slave));

  function automatic logic signed [9:0] sx(input logic signed [7:0] v);
    return {{2{v[7]}}, v};
  endfunction

  assign m_if.flush_i     = flush;
  assign m_if.in_valid_i  = in_valid;
  assign m_if.in_data_i   = in_data;
  assign m_if.out_ready_i = out_ready;
  assign w_if.flush_i     = flush;
  assign w_if.in_valid_i  = in_valid;
  assign w_if.in_data_i   = in_data;
  assign w_if.out_ready_i = out_ready;

  assign m_if.dct_dir_i[0] = sx(m_if.dct_dt_o[0]) + sx(m_if.dct_dt_o[1]) + sx(m_if.dct_dt_o[2]) + sx(m_if.dct_dt_o[3]);
  assign m_if.dct_dir_i[1] = sx(m_if.dct_dt_o[0]) - sx(m_if.dct_dt_o[3]);
  assign m_if.dct_dir_i[2] = sx(m_if.dct_dt_o[0]) - sx(m_if.dct_dt_o[1]) - sx(m_if.dct_dt_o[2]) + sx(m_if.dct_dt_o[3]);
  assign m_if.dct_dir_i[3] = sx(m_if.dct_dt_o[1]) - sx(m_if.dct_dt_o[2]);
  assign m_if.dct_inv_i[0] = m_if.dct_dt_o[3];
  assign m_if.dct_inv_i[1] = m_if.dct_dt_o[2];
  assign m_if.dct_inv_i[2] = m_if.dct_dt_o[1];
  assign m_if.dct_inv_i[3] = m_if.dct_dt_o[0];

  assign w_if.dct_dir_i[0] = sx(w_if.dct_dt_o[0]) + sx(w_if.dct_dt_o[1]) + sx(w_if.dct_dt_o[2]) + sx(w_if.dct_dt_o[3]);
  assign w_if.dct_dir_i[1] = sx(w_if.dct_dt_o[0]) - sx(w_if.dct_dt_o[3]);
  assign w_if.dct_dir_i[2] = sx(w_if.dct_dt_o[0]) - sx(w_if.dct_dt_o[1]) - sx(w_if.dct_dt_o[2]) + sx(w_if.dct_dt_o[3]);
  assign w_if.dct_dir_i[3] = sx(w_if.dct_dt_o[1]) - sx(w_if.dct_dt_o[2]);
  assign w_if.dct_inv_i[0] = w_if.dct_dt_o[3];
  assign w_if.dct_inv_i[1] = w_if.dct_dt_o[2];
  assign w_if.dct_inv_i[2] = w_if.dct_dt_o[1];
  assign w_if.dct_inv_i[3] = w_if.dct_dt_o[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected coefficients, worked by hand from the stand-in DCT above.
  int a_dir [4] = '{35, 5, -25, -10};     // block 5,10,20,0
  int a_inv [4] = '{0, 20, 10, 5};
  int b_dir [4] = '{208, 33, -118, 3};    // block 39,83,80,6
  int b_inv [4] = '{6, 80, 83, 39};
  int c_dir [4] = '{-6, -10, 14, 110};    // block -3,50,-60,7
  int c_inv [4] = '{7, -60, 50, -3};
  int f_dir [4] = '{-2, -128, -254, 128}; // block -128,127,-1,0
  int f_inv [4] = '{0, -1, 127, -128};
  int wrap_exp [5] = '{1, 2, 3, 0, 1};

  task automatic chk_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait (bounded) until an edge accepts it.
  task automatic push(input int v);
    bit was_ready;
    int n;
    in_valid = 1'b1;
    in_data  = v[7:0];
    n = 0;
    do begin
      was_ready = m_if.in_ready_o;
      tick();
      n++;
    end while (!was_ready && n < 20);
    if (!was_ready) chk_val("push_timeout", 0, 1);
  endtask

  task automatic push_block(input int d0, input int d1, input int d2, input int d3);
    push(d0);
    push(d1);
    push(d2);
    push(d3);
    in_valid = 1'b0;
  endtask

  task automatic expect_dt(input string tag, input int d0, input int d1, input int d2, input int d3);
    chk_val({tag, "_dt0"}, m_if.dct_dt_o[0], d0);
    chk_val({tag, "_dt1"}, m_if.dct_dt_o[1], d1);
    chk_val({tag, "_dt2"}, m_if.dct_dt_o[2], d2);
    chk_val({tag, "_dt3"}, m_if.dct_dt_o[3], d3);
  endtask

  task automatic expect_coef(input string tag, input int idx, input int dir, input int inv);
    chk_val($sformatf("%s_valid%0d", tag, idx), m_if.out_valid_o, 1);
    chk_val($sformatf("%s_idx%0d", tag, idx), m_if.out_idx_o, idx);
    chk_val($sformatf("%s_dir%0d", tag, idx), m_if.out_dir_o, dir);
    chk_val($sformatf("%s_inv%0d", tag, idx), m_if.out_inv_o, inv);
    chk_val($sformatf("%s_last%0d", tag, idx), m_if.out_last_o, (idx == 3) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit r;
    int k;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();

    // Reset values.
    chk_val("rst_in_ready", m_if.in_ready_o, 1);
    chk_val("rst_out_valid", m_if.out_valid_o, 0);
    chk_val("rst_idx", m_if.out_idx_o, 0);
    chk_val("rst_last", m_if.out_last_o, 0);
    chk_val("rst_dir", m_if.out_dir_o, 0);
    chk_val("rst_inv", m_if.out_inv_o, 0);
    chk_val("rst_blk", m_if.blk_cnt_o, 0);
    expect_dt("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Basic block with the sink always ready.
    out_ready = 1'b1;
    push_block(5, 10, 20, 0);
    expect_dt("basic", 5, 10, 20, 0);
    chk_val("basic_full_ready", m_if.in_ready_o, 0);
    chk_val("basic_valid_T", m_if.out_valid_o, 0);
    tick();
    chk_val("basic_ready_cap", m_if.in_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      expect_coef("basic", i, a_dir[i], a_inv[i]);
      tick();
    end
    chk_val("basic_valid_end", m_if.out_valid_o, 0);
    chk_val("basic_blk", m_if.blk_cnt_o, 1);

    // Overlap: second block gathered while the first is held by backpressure.
    out_ready = 1'b0;
    push_block(5, 10, 20, 0);
    push_block(8'h27, 8'h53, 8'h50, 8'h06);
    chk_val("ovl_in_ready", m_if.in_ready_o, 0);
    expect_dt("ovl", 39, 83, 80, 6);
    expect_coef("ovl_hold", 0, a_dir[0], a_inv[0]);
    tick();
    tick();
    expect_coef("ovl_hold2", 0, a_dir[0], a_inv[0]);
    chk_val("ovl_blk_hold", m_if.blk_cnt_o, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_coef("ovl_a", i, a_dir[i], a_inv[i]);
      tick();
    end
    chk_val("ovl_gap_valid", m_if.out_valid_o, 0);
    chk_val("ovl_gap_ready", m_if.in_ready_o, 0);
    chk_val("ovl_blk_a", m_if.blk_cnt_o, 2);
    tick();
    chk_val("ovl_cap_ready", m_if.in_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      expect_coef("ovl_b", i, b_dir[i], b_inv[i]);
      tick();
    end
    chk_val("ovl_blk_b", m_if.blk_cnt_o, 3);

    // Backpressure: sink readiness toggles every cycle.
    out_ready = 1'b0;
    push_block(-3, 50, -60, 7);
    tick();
    k = 0;
    for (int cyc = 0; cyc < 16 && k < 4; cyc++) begin
      expect_coef("bp", k, c_dir[k], c_inv[k]);
      r = out_ready;
      tick();
      if (r) k++;
      out_ready = !out_ready;
    end
    chk_val("bp_valid_end", m_if.out_valid_o, 0);
    chk_val("bp_blk", m_if.blk_cnt_o, 4);

    // Flush mid-block; the sample offered during the flush is discarded.
    out_ready = 1'b1;
    push(11);
    push(22);
    flush   = 1'b1;
    in_data = 8'd99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_val("flush_ready", m_if.in_ready_o, 1);
    chk_val("flush_valid", m_if.out_valid_o, 0);
    push_block(-128, 127, -1, 0);
    expect_dt("flush", -128, 127, -1, 0);
    chk_val("flush_blk", m_if.blk_cnt_o, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_coef("flush", i, f_dir[i], f_inv[i]);
      tick();
    end
    chk_val("flush_blk_after", m_if.blk_cnt_o, 5);

    // Asynchronous reset between edges while idx 2 is on the output.
    push_block(5, 10, 20, 0);
    tick();
    tick();
    tick();
    expect_coef("arst_pre", 2, a_dir[2], a_inv[2]);
    #2;
    rst = 1'b1;
    #1;
    chk_val("arst_valid", m_if.out_valid_o, 0);
    chk_val("arst_blk", m_if.blk_cnt_o, 0);
    chk_val("arst_ready", m_if.in_ready_o, 1);
    chk_val("arst_idx", m_if.out_idx_o, 0);
    chk_val("arst_dt0", m_if.dct_dt_o[0], 0);
    chk_val("arst_wrap_blk", w_if.blk_cnt_o, 0);
    #3;
    rst = 1'b0;
    tick();

    // Counter wrap on the 2-bit instance; the 16-bit one keeps counting.
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      push_block(b, b + 1, b + 2, b + 3);
      repeat (5) tick();
      chk_val($sformatf("wrap_blk%0d", b), w_if.blk_cnt_o, wrap_exp[b]);
      chk_val($sformatf("wide_blk%0d", b), m_if.blk_cnt_o, b + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
